// File: rtl/fc_dot_ctrl_pkg.sv
// fc_pkg: shared state encoding, Q-format widths and saturation limits for the FC dot-product sequencer
package fc_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int FRAC_DEFAULT = 8;
  localparam int DATA_W = 16;
  localparam int PROD_W = 32;
  localparam logic signed [DATA_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [DATA_W-1:0] SAT_MIN = 16'sh8000;
endpackage

// File: rtl/fc_dot_ctrl_if.sv
// fc_dot_ctrl_if: block handshake, operands, two ROM read ports and result of one neuron sequencer
// Ports: ap_start/ap_done/ap_idle/ap_ready handshake, len/bias operands, x_*/w_* read ports, y result.
// slave = the sequencer, master = the caller plus the memories.
interface fc_dot_ctrl_if #(parameter int AW = 10);
  import fc_pkg::*;
  logic ap_start;
  logic ap_done;
  logic ap_idle;
  logic ap_ready;
  logic [AW:0] len;
  logic signed [DATA_W-1:0] bias;
  logic [AW-1:0] x_address0;
  logic x_ce0;
  logic signed [DATA_W-1:0] x_q0;
  logic [AW-1:0] w_address0;
  logic w_ce0;
  logic signed [DATA_W-1:0] w_q0;
  logic signed [DATA_W-1:0] y;
  modport slave (
    input ap_start, len, bias, x_q0, w_q0,
    output ap_done, ap_idle, ap_ready, x_address0, x_ce0, w_address0, w_ce0, y
  );
  modport master (
    output ap_start, len, bias, x_q0, w_q0,
    input ap_done, ap_idle, ap_ready, x_address0, x_ce0, w_address0, w_ce0, y
  );
endinterface

// File: rtl/fc_dot_ctrl_mac_mul16.sv
// fc_mac_mul16: combinational 16x16 signed multiplier feeding the registered product stage
// Ports: i_a, i_b signed operands; o_p full-precision signed product.
module fc_mac_mul16
  import fc_pkg::*;
(
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic signed [PROD_W-1:0] o_p
);
  assign o_p = i_a * i_b;
endmodule

// File: rtl/fc_dot_ctrl.sv
// fc_dot_ctrl: streams LEN x/w pairs through one multiplier, accumulates, adds bias, rescales, ReLU, saturates
// Ports: ap_clk, ap_rst_n (async, active low); s = slave side of fc_dot_ctrl_if.
module fc_dot_ctrl
  import fc_pkg::*;
#(
  parameter int MAX_LEN = 1024,
  parameter int AW = 10,
  parameter int ACC_W = 40,
  parameter int FRAC = FRAC_DEFAULT,
  parameter int RELU = 1
) (
  input logic ap_clk,
  input logic ap_rst_n,
  fc_dot_ctrl_if.slave s
);
  // accumulator is widened if needed so that a full MAX_LEN run of extreme products cannot wrap
  localparam int AI_W = (ACC_W > PROD_W + AW + 1) ? ACC_W : PROD_W + AW + 1;
  state_t r_state, w_next;
  logic [AW:0] r_len, w_len;
  logic signed [DATA_W-1:0] r_bias, r_y, w_y;
  logic [AW-1:0] r_idx;
  logic [1:0] r_drain;
  logic r_v1, r_v2, w_last, w_start, w_run;
  logic signed [PROD_W-1:0] w_p, r_p;
  logic signed [AI_W-1:0] r_acc, w_s, w_r, w_rl;
  fc_mac_mul16 u_mul (.i_a(s.x_q0), .i_b(s.w_q0), .o_p(w_p));
  assign w_len = (s.len > (AW+1)'(MAX_LEN)) ? (AW+1)'(MAX_LEN) : s.len;
  assign w_start = (r_state == IDLE) && s.ap_start;
  assign w_run = (r_state == RUN);
  assign w_last = ({1'b0, r_idx} == r_len - 1'b1);
  assign s.ap_idle = (r_state == IDLE);
  assign s.ap_done = (r_state == DONE);
  assign s.ap_ready = (r_state == DONE);
  assign s.x_ce0 = w_run;
  assign s.w_ce0 = w_run;
  assign s.x_address0 = r_idx;
  assign s.w_address0 = r_idx;
  assign s.y = r_y;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = s.ap_start ? ((w_len == '0) ? DRAIN : RUN) : IDLE;
      RUN: w_next = w_last ? DRAIN : RUN;
      DRAIN: w_next = (r_drain == 2'd2) ? DONE : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    w_s = r_acc + ({{(AI_W-DATA_W){r_bias[DATA_W-1]}}, r_bias} << FRAC);
    w_r = w_s >>> FRAC;
    w_rl = (RELU != 0 && w_r < 0) ? '0 : w_r;
    w_y = (w_rl > AI_W'(SAT_MAX)) ? SAT_MAX : (w_rl < AI_W'(SAT_MIN)) ? SAT_MIN : w_rl[DATA_W-1:0];
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= IDLE;
      r_len <= '0;
      r_bias <= '0;
      r_idx <= '0;
      r_drain <= '0;
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_p <= '0;
      r_acc <= '0;
      r_y <= '0;
    end else begin
      r_state <= w_next;
      r_v1 <= w_run;
      r_v2 <= r_v1;
      r_p <= w_p;
      r_drain <= (r_state == DRAIN) ? r_drain + 2'd1 : 2'd0;
      if (w_start) begin
        r_len <= w_len;
        r_bias <= s.bias;
        r_idx <= '0;
        r_acc <= '0;
      end else begin
        if (w_run) r_idx <= r_idx + 1'b1;
        if (r_v2) r_acc <= r_acc + {{(AI_W-PROD_W){r_p[PROD_W-1]}}, r_p};
      end
      // the last product lands in the accumulator on the edge ending the second drain cycle
      if (r_state == DRAIN && r_drain == 2'd2) r_y <= w_y;
    end
  end
endmodule

// File: tb/tb_fc_dot_ctrl.sv
// tb_fc_dot_ctrl: scoreboard bench driving a RELU=0 and a RELU=1 instance with identical stimulus
module tb_fc_dot_ctrl;
  import fc_pkg::*;
  typedef struct {
    int t;
    logic signed [15:0] y0;
    logic signed [15:0] y1;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int ce_cnt = 0;
  int n_chk = 0;
  int n_fail = 0;
  int n_done = 0;
  exp_t q[$];
  logic signed [15:0] xm [1024];
  logic signed [15:0] wm [1024];
  logic signed [15:0] xq = '0;
  logic signed [15:0] wq = '0;
  always #5 clk = ~clk;
  fc_dot_ctrl_if #(.AW(10)) a ();
  fc_dot_ctrl_if #(.AW(10)) b ();
  fc_dot_ctrl #(.RELU(0)) u0 (.ap_clk(clk), .ap_rst_n(rst_n), .s(a));
  fc_dot_ctrl #(.RELU(1)) u1 (.ap_clk(clk), .ap_rst_n(rst_n), .s(b));
  assign a.x_q0 = xq;
  assign a.w_q0 = wq;
  assign b.ap_start = a.ap_start;
  assign b.len = a.len;
  assign b.bias = a.bias;
  assign b.x_q0 = xq;
  assign b.w_q0 = wq;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a.x_ce0) begin
      xq <= xm[a.x_address0];
      ce_cnt <= ce_cnt + 1;
    end
    if (a.w_ce0) wq <= wm[a.w_address0];
  end
  task automatic chk(string nm, longint act, longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (a.ap_done || b.ap_done) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done at cycle %0d: no result was expected", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_cycle", cyc, e.t);
        chk("y_relu0", a.y, e.y0);
        chk("y_relu1", b.y, e.y1);
        chk("ready_with_done", a.ap_ready, 1);
        chk("done_pair", b.ap_done, 1);
        n_done++;
      end
    end
  end
  task automatic wait_done(int target);
    int k = 0;
    while (n_done < target && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (n_done < target) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got %0d results expected %0d", n_done, target);
    end
  endtask
  task automatic run_op(string nm, int len_in, int n, logic signed [15:0] bias,
                        logic signed [15:0] y0, logic signed [15:0] y1);
    int t0, c0, tgt, busy;
    @(negedge clk);
    chk({nm, "_idle_before"}, a.ap_idle, 1);
    a.len = 11'(len_in);
    a.bias = bias;
    a.ap_start = 1'b1;
    t0 = cyc;
    c0 = ce_cnt;
    tgt = n_done + 1;
    q.push_back('{t0 + n + 4, y0, y1});
    @(negedge clk);
    a.ap_start = 1'b0;
    a.bias = ~bias;
    a.len = 11'd5;
    busy = 0;
    for (int i = 0; i < n + 4; i++) begin
      if (!a.ap_idle) busy++;
      @(negedge clk);
    end
    chk({nm, "_busy_cycles"}, busy, n + 4);
    chk({nm, "_idle_after"}, a.ap_idle, 1);
    wait_done(tgt);
    chk({nm, "_ce_count"}, ce_cnt - c0, n);
  endtask
  initial begin
    int t0, tgt;
    a.ap_start = 1'b0;
    a.len = '0;
    a.bias = '0;
    for (int i = 0; i < 1024; i++) begin
      xm[i] = '0;
      wm[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_idle", a.ap_idle, 1);
    chk("rst_done", a.ap_done, 0);
    chk("rst_ready", a.ap_ready, 0);
    chk("rst_xce", a.x_ce0, 0);
    chk("rst_wce", a.w_ce0, 0);
    chk("rst_xaddr", a.x_address0, 0);
    chk("rst_y", a.y, 0);
    rst_n = 1'b1;
    // reset in the middle of an N=8 run, before any result exists
    for (int i = 0; i < 8; i++) begin
      xm[i] = 16'sd256;
      wm[i] = 16'sd256;
    end
    @(negedge clk);
    a.len = 11'd8;
    a.ap_start = 1'b1;
    @(negedge clk);
    a.ap_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_run_ce", a.x_ce0, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_drops_xce", a.x_ce0, 0);
    chk("reset_drops_wce", a.w_ce0, 0);
    chk("reset_idle", a.ap_idle, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("reset_y0_kept", a.y, 0);
    chk("reset_y1_kept", b.y, 0);
    xm[0] = 16'sd1280;
    wm[0] = 16'sd256;
    run_op("after_reset", 1, 1, 16'sd0, 16'sd1280, 16'sd1280);
    xm[0] = 16'sd256; xm[1] = 16'sd512; xm[2] = 16'sd768; xm[3] = 16'sd1024;
    for (int i = 0; i < 4; i++) wm[i] = 16'sd256;
    run_op("n4", 4, 4, 16'sd0, 16'sd2560, 16'sd2560);
    run_op("n0", 0, 0, 16'sh0180, 16'sd384, 16'sd384);
    xm[0] = 16'sh7FFF; xm[1] = 16'sh7FFF; wm[0] = 16'sh7FFF; wm[1] = 16'sh7FFF;
    run_op("sat_pos", 2, 2, 16'sd0, 16'sd32767, 16'sd32767);
    wm[0] = 16'sh8000; wm[1] = 16'sh8000;
    run_op("sat_neg", 2, 2, 16'sd0, -16'sd32768, 16'sd0);
    xm[0] = -16'sd256; wm[0] = 16'sd256;
    run_op("relu", 1, 1, 16'sd0, -16'sd256, 16'sd0);
    xm[0] = -16'sd1; wm[0] = 16'sd1;
    run_op("floor", 1, 1, 16'sd0, -16'sd1, 16'sd0);
    xm[0] = 16'sd3; wm[0] = 16'sd256;
    run_op("neg_bias", 1, 1, -16'sd1, 16'sd2, 16'sd2);
    for (int i = 0; i < 1024; i++) begin
      xm[i] = 16'sd1;
      wm[i] = 16'sd1;
    end
    run_op("len_clamp", 2047, 1024, 16'sd0, 16'sd4, 16'sd4);
    // start held high: two N=3 runs, bias changed during the first one
    for (int i = 0; i < 3; i++) begin
      xm[i] = 16'sd256;
      wm[i] = 16'sd256;
    end
    @(negedge clk);
    a.len = 11'd3;
    a.bias = 16'sd16;
    a.ap_start = 1'b1;
    t0 = cyc;
    tgt = n_done + 2;
    q.push_back('{t0 + 7, 16'sd784, 16'sd784});
    q.push_back('{t0 + 15, 16'sd668, 16'sd668});
    repeat (2) @(negedge clk);
    a.bias = -16'sd100;
    repeat (7) @(negedge clk);
    a.ap_start = 1'b0;
    wait_done(tgt);
    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
